// File: rtl/sdram_row_pkg.sv
// Shared command encodings, FSM state type and sizing helpers for the row-buffer controller.
// No logic of its own; imported by the store and the controller.
package sdram_row_pkg;

  localparam int WORDS_DEFAULT = 64;
  localparam int WIDTH_DEFAULT = 32;
  localparam int COL_WIDTH     = $clog2(WORDS_DEFAULT);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVATE  = 2'd1,
    ST_OPEN      = 2'd2,
    ST_WRITEBACK = 2'd3
  } rowState_t;

  // Width of a down-counter that must hold the larger of two strobe lengths.
  function automatic int timerBits(input int a, input int b);
    int maxVal;
    maxVal = (a > b) ? a : b;
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/row_buffer_store.sv
// WORDS x WIDTH row register array: full-row load, single-word write, combinational word read.
// Updates land on the clock edge; no backpressure, clear has priority over load, load over write.
module row_buffer_store
  import sdram_row_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   loadEn,
  input  logic [WORDS*WIDTH-1:0] loadData,
  input  logic                   wrEn,
  input  logic [AW-1:0]          wrAddr,
  input  logic [WIDTH-1:0]       wrData,
  input  logic [AW-1:0]          rdAddr,
  output logic [WIDTH-1:0]       rdWord,
  output logic [WORDS*WIDTH-1:0] rowFlat
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (loadEn) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= loadData[i*WIDTH +: WIDTH];
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdWord = mem[rdAddr];

  for (genvar g = 0; g < WORDS; g++) begin : gFlat
    assign rowFlat[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/sdram_row_buffer.sv
// Row-buffer controller: ACT captures a core row after T_RCD, RD/WR hit the buffer (RD data 1 cycle later),
// PRE writes back for T_WR cycles only when dirty; CmdReady drops while ACTIVATE/WRITEBACK strobes run.
module sdram_row_buffer
  import sdram_row_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int T_RCD = 2,
  parameter int T_WR  = 1,
  localparam int ColW = $clog2(WORDS)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   CmdValid,
  input  logic [2:0]             Cmd,
  output logic                   CmdReady,
  input  logic [ColW-1:0]        Col,
  input  logic [WIDTH-1:0]       WrData,
  output logic [WIDTH-1:0]       RdData,
  output logic                   RdValid,
  output logic                   Err,
  output logic                   RowOpen,
  output logic                   RowEnable,
  output logic                   RE,
  output logic                   WE,
  input  logic [WORDS*WIDTH-1:0] RowDataOut,
  output logic [WORDS*WIDTH-1:0] RowDataIn
);

  localparam int TimerW = timerBits(T_RCD, T_WR);

  rowState_t          state;
  logic [TimerW-1:0]  timer;
  logic               dirty;
  logic               accept;
  logic               captureRow;
  logic               colWrite;
  logic [WIDTH-1:0]   bufWord;

  assign CmdReady   = (state == ST_IDLE) || (state == ST_OPEN);
  assign accept     = CmdValid && CmdReady;
  assign captureRow = (state == ST_ACTIVATE) && (timer == '0);
  assign colWrite   = accept && (state == ST_OPEN) && (Cmd == CMD_WR);

  row_buffer_store #(
    .WORDS(WORDS),
    .WIDTH(WIDTH)
  ) uStore (
    .clk     (Clk),
    .resetN  (Reset_n),
    .loadEn  (captureRow),
    .loadData(RowDataOut),
    .wrEn    (colWrite),
    .wrAddr  (Col),
    .wrData  (WrData),
    .rdAddr  (Col),
    .rdWord  (bufWord),
    .rowFlat (RowDataIn)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      dirty     <= 1'b0;
      RowEnable <= 1'b0;
      RE        <= 1'b0;
      WE        <= 1'b0;
      RdValid   <= 1'b0;
      Err       <= 1'b0;
      RowOpen   <= 1'b0;
      RdData    <= '0;
    end else begin
      RdValid <= 1'b0;
      Err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (Cmd)
              CMD_ACT: begin
                state     <= ST_ACTIVATE;
                RowEnable <= 1'b1;
                RE        <= 1'b1;
                timer     <= TimerW'(T_RCD - 1);
              end
              CMD_RD, CMD_WR, CMD_PRE: Err <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_ACTIVATE: begin
          // The store captures RowDataOut on this same edge via captureRow.
          if (timer == '0) begin
            state     <= ST_OPEN;
            RowEnable <= 1'b0;
            RE        <= 1'b0;
            RowOpen   <= 1'b1;
            dirty     <= 1'b0;
          end else begin
            timer <= timer - TimerW'(1);
          end
        end
        ST_OPEN: begin
          if (accept) begin
            case (Cmd)
              CMD_RD: begin
                RdData  <= bufWord;
                RdValid <= 1'b1;
              end
              CMD_WR:  dirty <= 1'b1;
              CMD_PRE: begin
                if (dirty) begin
                  state     <= ST_WRITEBACK;
                  RowEnable <= 1'b1;
                  WE        <= 1'b1;
                  timer     <= TimerW'(T_WR - 1);
                end else begin
                  state   <= ST_IDLE;
                  RowOpen <= 1'b0;
                end
              end
              CMD_ACT: Err <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_WRITEBACK: begin
          if (timer == '0) begin
            state     <= ST_IDLE;
            RowEnable <= 1'b0;
            WE        <= 1'b0;
            RowOpen   <= 1'b0;
            dirty     <= 1'b0;
          end else begin
            timer <= timer - TimerW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_row_buffer.sv
// Directed bench for sdram_row_buffer (T_RCD=2, T_WR=3): inputs driven and outputs sampled on the falling edge.
module tb_sdram_row_buffer;
  import sdram_row_pkg::*;

  localparam int WORDS = 64;
  localparam int WIDTH = 32;

  logic                   Clk = 1'b0;
  logic                   Reset_n;
  logic                   CmdValid;
  logic [2:0]             Cmd;
  logic                   CmdReady;
  logic [5:0]             Col;
  logic [WIDTH-1:0]       WrData;
  logic [WIDTH-1:0]       RdData;
  logic                   RdValid;
  logic                   Err;
  logic                   RowOpen;
  logic                   RowEnable;
  logic                   RE;
  logic                   WE;
  logic [WORDS*WIDTH-1:0] RowDataOut;
  logic [WORDS*WIDTH-1:0] RowDataIn;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  sdram_row_buffer #(
    .WORDS(WORDS),
    .WIDTH(WIDTH),
    .T_RCD(2),
    .T_WR (3)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .CmdValid  (CmdValid),
    .Cmd       (Cmd),
    .CmdReady  (CmdReady),
    .Col       (Col),
    .WrData    (WrData),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .Err       (Err),
    .RowOpen   (RowOpen),
    .RowEnable (RowEnable),
    .RE        (RE),
    .WE        (WE),
    .RowDataOut(RowDataOut),
    .RowDataIn (RowDataIn)
  );

  function automatic logic [31:0] coreWord(input int i);
    return (i == 10) ? 32'h1122_3344 : (32'hC0DE_0000 | 32'(i));
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one command for a single edge; returns in the cycle after the accept edge.
  task automatic sendCmd(input logic [2:0] c, input logic [5:0] col, input logic [31:0] d);
    CmdValid = 1'b1;
    Cmd      = c;
    Col      = col;
    WrData   = d;
    @(negedge Clk);
    CmdValid = 1'b0;
    Cmd      = CMD_NOP;
  endtask

  task automatic waitOpen();
    int n = 0;
    while (!RowOpen && n < 20) begin
      @(negedge Clk);
      n++;
    end
    checkVal("open_wait", 64'(RowOpen), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int weCnt;
    int overlap;
    int diffs;
    Reset_n  = 1'b0;
    CmdValid = 1'b0;
    Cmd      = CMD_NOP;
    Col      = '0;
    WrData   = '0;
    for (int i = 0; i < WORDS; i++) RowDataOut[i*WIDTH +: WIDTH] = coreWord(i);
    repeat (3) @(negedge Clk);

    checkVal("rst_strobes", 64'({RowEnable, RE, WE}), 64'(0));
    checkVal("rst_flags", 64'({RdValid, Err, RowOpen}), 64'(0));
    checkVal("rst_rddata", 64'(RdData), 64'(0));
    checkVal("rst_rowdata_zero", 64'(RowDataIn == '0), 64'(1));
    Reset_n = 1'b1;
    @(negedge Clk);
    checkVal("ready_after_rst", 64'(CmdReady), 64'(1));

    // Activate: RE for exactly two cycles, then row open.
    sendCmd(CMD_ACT, 6'd0, 32'd0);
    checkVal("act_c1_re", 64'({RowEnable, RE, WE}), 64'(3'b110));
    checkVal("act_c1_ready", 64'({CmdReady, RowOpen}), 64'(2'b00));
    @(negedge Clk);
    checkVal("act_c2_re", 64'({RowEnable, RE}), 64'(2'b11));
    @(negedge Clk);
    checkVal("act_done_re", 64'({RowEnable, RE}), 64'(2'b00));
    checkVal("act_done_open", 64'({RowOpen, CmdReady}), 64'(2'b11));

    sendCmd(CMD_RD, 6'd10, 32'd0);
    checkVal("rd10", 64'({RdValid, RdData}), {31'd0, 1'b1, 32'h1122_3344});
    @(negedge Clk);
    checkVal("rd10_pulse_end", 64'(RdValid), 64'(0));

    // Dirty precharge: write-back for three cycles.
    sendCmd(CMD_WR, 6'd10, 32'hDEAD_BEEF);
    sendCmd(CMD_PRE, 6'd0, 32'd0);
    checkVal("wb_c1_strobes", 64'({RowEnable, RE, WE, CmdReady}), 64'(4'b1010));
    checkVal("wb_word10", 64'(RowDataIn[10*WIDTH +: WIDTH]), 64'(32'hDEAD_BEEF));
    diffs = 0;
    for (int i = 0; i < WORDS; i++)
      if (i != 10 && RowDataIn[i*WIDTH +: WIDTH] !== coreWord(i)) diffs++;
    checkVal("wb_other_words", 64'(diffs), 64'(0));
    weCnt = 0;
    overlap = 0;
    for (int k = 0; k < 6; k++) begin
      if (WE) weCnt++;
      if (WE && RE) overlap++;
      @(negedge Clk);
    end
    checkVal("wb_we_cycles", 64'(weCnt), 64'(3));
    checkVal("wb_no_overlap", 64'(overlap), 64'(0));
    checkVal("wb_idle", 64'({RowOpen, CmdReady, RowEnable}), 64'(3'b010));

    // Full-row back-to-back read sweep, then clean precharge.
    sendCmd(CMD_ACT, 6'd0, 32'd0);
    waitOpen();
    for (int c = 0; c < WORDS; c++) begin
      CmdValid = 1'b1;
      Cmd      = CMD_RD;
      Col      = 6'(c);
      @(negedge Clk);
      checkVal($sformatf("sweep_rd%0d", c), 64'({RdValid, RdData}), {31'd0, 1'b1, coreWord(c)});
    end
    sendCmd(CMD_PRE, 6'd0, 32'd0);
    checkVal("clean_pre_idle", 64'({RowOpen, CmdReady, WE, RowEnable}), 64'(4'b0100));
    weCnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (WE || RowEnable) weCnt++;
      @(negedge Clk);
    end
    checkVal("clean_pre_no_we", 64'(weCnt), 64'(0));

    // Illegal commands.
    sendCmd(CMD_RD, 6'd3, 32'd0);
    checkVal("err_rd_idle", 64'({Err, RdValid, RE, RowOpen, CmdReady}), 64'(5'b10001));
    @(negedge Clk);
    checkVal("err_rd_idle_end", 64'(Err), 64'(0));
    sendCmd(CMD_ACT, 6'd0, 32'd0);
    waitOpen();
    sendCmd(CMD_ACT, 6'd0, 32'd0);
    checkVal("err_act_open", 64'({Err, RowEnable, RE, RowOpen, CmdReady}), 64'(5'b10011));
    @(negedge Clk);
    checkVal("err_act_open_end", 64'({Err, RowOpen}), 64'(2'b01));

    // Write then read the same column on the next cycle.
    CmdValid = 1'b1;
    Cmd      = CMD_WR;
    Col      = 6'd5;
    WrData   = 32'hA5A5_A5A5;
    @(negedge Clk);
    Cmd = CMD_RD;
    @(negedge Clk);
    CmdValid = 1'b0;
    Cmd      = CMD_NOP;
    checkVal("wr_then_rd5", 64'({RdValid, RdData}), {31'd0, 1'b1, 32'hA5A5_A5A5});

    // Reset during the first write-back cycle.
    sendCmd(CMD_PRE, 6'd0, 32'd0);
    checkVal("wb2_c1_we", 64'({RowEnable, WE}), 64'(2'b11));
    Reset_n = 1'b0;
    @(negedge Clk);
    checkVal("abort_strobes", 64'({RowEnable, RE, WE}), 64'(0));
    checkVal("abort_flags", 64'({RdValid, Err, RowOpen}), 64'(0));
    checkVal("abort_rddata", 64'(RdData), 64'(0));
    checkVal("abort_rowdata_zero", 64'(RowDataIn == '0), 64'(1));
    Reset_n = 1'b1;
    @(negedge Clk);
    checkVal("abort_ready", 64'({CmdReady, WE}), 64'(2'b10));

    // Dirty flag must be gone: fresh row, clean precharge.
    sendCmd(CMD_ACT, 6'd0, 32'd0);
    waitOpen();
    sendCmd(CMD_RD, 6'd5, 32'd0);
    checkVal("reload_rd5", 64'({RdValid, RdData}), {31'd0, 1'b1, coreWord(5)});
    sendCmd(CMD_PRE, 6'd0, 32'd0);
    checkVal("post_abort_clean_pre", 64'({WE, RowEnable, RowOpen, CmdReady}), 64'(4'b0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
